pipelined_control: RTL and testbench
====================================

Name: pipelined_control

Overview:
- Decodes RV32I opcode/fun_3/fun_7 (optionally RV32M) into datapath control fields, and registers them into an ID/EX control register with valid bit.
- Generates the decode-stage stall for load-use hazards, cache busy and multi-cycle mul/div waits. Inserts bubbles on flush.
- Sits between the instruction register and the execute/memory stages. It is the pipelined successor of the single-cycle control decoder.

Parameters:
- ALU_OP_W, 4, alu_op width. 3 = alu_op is fun_3 only; 4 = alu_op is {fun_7[5] qualifier, fun_3}.
- REG_ADDR_W, 5, register index width.
- ENABLE_M_EXT, 0, 1 = decode opcode 0110011 with fun_7=0000001 as mul/div.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- instr_valid  in  1  decode-stage instruction present
- opcode  in  7  instruction[6:0]
- fun_3  in  3  instruction[14:12]
- fun_7  in  7  instruction[31:25]
- rs1, rs2, rd  in  REG_ADDR_W  decode-stage register indices
- flush  in  1  branch/jump taken; kill decode-stage instruction
- d_mem_busy  in  1  data cache not ready
- muldiv_done  in  1  mul/div result ready
- stall_id  out  1  hold PC and IF/ID register
- ex_valid  out  1  ex_* bundle is a real instruction
- ex_rd  out  REG_ADDR_W  destination of EX instruction
- ex_d_mem_r, ex_d_mem_w, ex_jump, ex_branch, ex_wrten_reg, ex_mux_d_mem, ex_mux_inp_1, ex_mux_inp_2, ex_mux_complmnt, ex_muldiv, ex_illegal  out  1 each  registered control
- ex_mux_result  out  2  result select
- ex_mux_wire_module  out  3  immediate-format select
- ex_alu_op  out  ALU_OP_W  ALU operation

Behaviour:
- Reset (async, reset_n=0): every ex_* output 0, ex_valid 0, stall_id 0, state RUN, flush_pend 0.
- Decode is combinational. Encodings are fixed, given as (mux_result, mux_wire_module, inp_1, inp_2, mux_d_mem, wrten_reg):
  - LUI 0110111: (1,3,0,0,1,1)
  - AUIPC 0010111: (2,3,1,1,1,1)
  - JAL 1101111: (3,1,1,1,1,1), jump=1
  - JALR 1100111: (3,4,0,1,1,1), jump=1
  - BRANCH 1100011: (0,0,0,0,0,0), branch=1, complmnt=1
  - LOAD 0000011: (2,4,0,1,0,1), d_mem_r=1
  - STORE 0100011: (2,2,0,1,0,0), d_mem_w=1
  - OP-IMM 0010011: (2,4,0,1,1,1)
  - OP 0110011: (2,0,0,0,1,1), complmnt=fun_7[5]
- alu_op:
  - Only OP and OP-IMM set it. Every other listed opcode gives alu_op=0.
  - Low 3 bits = fun_3.
  - When ALU_OP_W=4, bit3 = fun_7[5] for OP, and for OP-IMM only when fun_3=101 (SRAI); otherwise 0.
- Unknown opcode: all controls 0, illegal=1, wrten_reg=0.
- M-extension: OP with fun_7=0000001 and ENABLE_M_EXT=1 gives muldiv=1 and complmnt=0. With ENABLE_M_EXT=0 the same encoding decodes as illegal.
- Latency: decode registered into ex_* at the next rising edge when advancing (1 cycle).
- Decoded bundle is zeroed when instr_valid=0.
- States:
  - RUN: normal.
  - MEM_WAIT: ex_valid & (ex_d_mem_r|ex_d_mem_w) & d_mem_busy.
  - MUL_WAIT: ex_valid & ex_muldiv & !muldiv_done.
  - Transitions out of RUN are evaluated every cycle on the current ex_* bundle.
- In wait states:
  - ex_* is held and stall_id=1.
  - Exit to RUN on the cycle the condition clears. stall_id drops in that same cycle (combinational), and ex_* advances on that edge.
- load_use = ex_valid & ex_d_mem_r & ex_rd!=0 & instr_valid & (ex_rd==rs1 | ex_rd==rs2).
- RUN priority per edge:
  - flush: ex bundle cleared, ex_valid=0.
  - otherwise load_use: bubble inserted (ex cleared), stall_id=1 for that cycle only.
  - otherwise: advance.
- Flush during a wait state is latched in flush_pend. On exit, the next edge loads a bubble instead of decode, then flush_pend clears.
- Simultaneous flush and load_use: flush wins, stall_id=0.
- ex_rd is cleared to 0 with every bubble.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode localparams
  - mux_result / mux_wire_module encodings
  - state enum {RUN, MEM_WAIT, MUL_WAIT}
  - control bundle struct
- Sub-module ctrl_decode: the pure combinational decoder, reused by the single-cycle core.

Test Plan:
- Reset: reset_n=0 mid-MEM_WAIT → all ex_* 0, stall_id 0 immediately, without waiting for a clock edge.
- Decode: ADDI x1 then SUB x2 (ALU_OP_W=4) → after 1 edge ex_alu_op=0000, mux_wire_module=4, inp_2=1; next edge ex_alu_op=1000, complmnt=1, mux_result=2.
- Load-use: LW x5 then ADD x6,x5,x7 → stall_id=1 for exactly 1 cycle, one bubble (ex_valid=0), then ADD enters EX. LW x0 followed by a use of x0 → no stall.
- Cache busy: LW in EX, d_mem_busy high 3 cycles → MEM_WAIT, stall_id=1 for 3 cycles, ex_* stable. Flush pulsed during the wait → bubble after exit.
- M-ext: MUL (fun_7=0000001) with ENABLE_M_EXT=1 → ex_muldiv=1, MUL_WAIT until muldiv_done. With ENABLE_M_EXT=0 → ex_illegal=1.
- Flush priority: flush and load_use in the same cycle → ex_valid=0, stall_id=0. Unknown opcode 1111111 → ex_illegal=1, ex_wrten_reg=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings and types for the RV32I(M) control decoder and its pipelined wrapper.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUN7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUN3_SR     = 3'b101;

    // Writeback result select.
    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_IMM  = 2'd1;
    localparam logic [1:0] RES_ALU  = 2'd2;
    localparam logic [1:0] RES_LINK = 2'd3;

    // Immediate-format select.
    localparam logic [2:0] WM_R = 3'd0;
    localparam logic [2:0] WM_J = 3'd1;
    localparam logic [2:0] WM_S = 3'd2;
    localparam logic [2:0] WM_U = 3'd3;
    localparam logic [2:0] WM_I = 3'd4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MUL_WAIT = 2'd2
    } state_t;

    // alu_op is carried at its widest; narrower configurations take the low bits.
    typedef struct packed {
        logic       d_mem_r;
        logic       d_mem_w;
        logic       jump;
        logic       branch;
        logic       wrten_reg;
        logic       mux_d_mem;
        logic       mux_inp_1;
        logic       mux_inp_2;
        logic       mux_complmnt;
        logic       muldiv;
        logic       illegal;
        logic [1:0] mux_result;
        logic [2:0] mux_wire_module;
        logic [3:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/pipelined_control_if.sv
// Decode-stage inputs, hazard inputs and the registered ID/EX control bundle.
interface pipelined_control_if #(
    parameter int ALU_OP_W   = 4,
    parameter int REG_ADDR_W = 5
);
    logic                  instr_valid;
    logic [6:0]            opcode;
    logic [2:0]            fun_3;
    logic [6:0]            fun_7;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  flush;
    logic                  d_mem_busy;
    logic                  muldiv_done;

    logic                  stall_id;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_d_mem_r;
    logic                  ex_d_mem_w;
    logic                  ex_jump;
    logic                  ex_branch;
    logic                  ex_wrten_reg;
    logic                  ex_mux_d_mem;
    logic                  ex_mux_inp_1;
    logic                  ex_mux_inp_2;
    logic                  ex_mux_complmnt;
    logic                  ex_muldiv;
    logic                  ex_illegal;
    logic [1:0]            ex_mux_result;
    logic [2:0]            ex_mux_wire_module;
    logic [ALU_OP_W-1:0]   ex_alu_op;

    modport master (
        output instr_valid, opcode, fun_3, fun_7, rs1, rs2, rd,
               flush, d_mem_busy, muldiv_done,
        input  stall_id, ex_valid, ex_rd, ex_d_mem_r, ex_d_mem_w, ex_jump,
               ex_branch, ex_wrten_reg, ex_mux_d_mem, ex_mux_inp_1,
               ex_mux_inp_2, ex_mux_complmnt, ex_muldiv, ex_illegal,
               ex_mux_result, ex_mux_wire_module, ex_alu_op
    );

    modport slave (
        input  instr_valid, opcode, fun_3, fun_7, rs1, rs2, rd,
               flush, d_mem_busy, muldiv_done,
        output stall_id, ex_valid, ex_rd, ex_d_mem_r, ex_d_mem_w, ex_jump,
               ex_branch, ex_wrten_reg, ex_mux_d_mem, ex_mux_inp_1,
               ex_mux_inp_2, ex_mux_complmnt, ex_muldiv, ex_illegal,
               ex_mux_result, ex_mux_wire_module, ex_alu_op
    );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational RV32I(M) control decoder, shared with the single-cycle core.
module ctrl_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_OP_W     = 4,
    parameter int ENABLE_M_EXT = 0
) (
    input  logic       instr_valid,
    input  logic [6:0] opcode,
    input  logic [2:0] fun_3,
    input  logic [6:0] fun_7,
    output ctrl_t      ctrl
);
    localparam bit WIDE_ALU_OP = (ALU_OP_W >= 4);
    localparam bit M_EXT       = (ENABLE_M_EXT != 0);

    always_comb begin
        // NOTE: full default first so no path through the case leaves ctrl unassigned (no latch).
        ctrl = '0;
        if (instr_valid) begin
            case (opcode)
                OPC_LUI: begin
                    ctrl.mux_result      = RES_IMM;
                    ctrl.mux_wire_module = WM_U;
                    ctrl.mux_d_mem       = 1'b1;
                    ctrl.wrten_reg       = 1'b1;
                end
                OPC_AUIPC: begin
                    ctrl.mux_result      = RES_ALU;
                    ctrl.mux_wire_module = WM_U;
                    ctrl.mux_inp_1       = 1'b1;
                    ctrl.mux_inp_2       = 1'b1;
                    ctrl.mux_d_mem       = 1'b1;
                    ctrl.wrten_reg       = 1'b1;
                end
                OPC_JAL: begin
                    ctrl.mux_result      = RES_LINK;
                    ctrl.mux_wire_module = WM_J;
                    ctrl.mux_inp_1       = 1'b1;
                    ctrl.mux_inp_2       = 1'b1;
                    ctrl.mux_d_mem       = 1'b1;
                    ctrl.wrten_reg       = 1'b1;
                    ctrl.jump            = 1'b1;
                end
                OPC_JALR: begin
                    ctrl.mux_result      = RES_LINK;
                    ctrl.mux_wire_module = WM_I;
                    ctrl.mux_inp_2       = 1'b1;
                    ctrl.mux_d_mem       = 1'b1;
                    ctrl.wrten_reg       = 1'b1;
                    ctrl.jump            = 1'b1;
                end
                OPC_BRANCH: begin
                    ctrl.branch       = 1'b1;
                    ctrl.mux_complmnt = 1'b1;
                end
                OPC_LOAD: begin
                    ctrl.mux_result      = RES_ALU;
                    ctrl.mux_wire_module = WM_I;
                    ctrl.mux_inp_2       = 1'b1;
                    ctrl.wrten_reg       = 1'b1;
                    ctrl.d_mem_r         = 1'b1;
                end
                OPC_STORE: begin
                    ctrl.mux_result      = RES_ALU;
                    ctrl.mux_wire_module = WM_S;
                    ctrl.mux_inp_2       = 1'b1;
                    ctrl.d_mem_w         = 1'b1;
                end
                OPC_OP_IMM: begin
                    ctrl.mux_result      = RES_ALU;
                    ctrl.mux_wire_module = WM_I;
                    ctrl.mux_inp_2       = 1'b1;
                    ctrl.mux_d_mem       = 1'b1;
                    ctrl.wrten_reg       = 1'b1;
                    // Only SRAI carries the arithmetic qualifier among the immediates.
                    ctrl.alu_op = {WIDE_ALU_OP && (fun_3 == FUN3_SR) && fun_7[5], fun_3};
                end
                OPC_OP: begin
                    if (fun_7 == FUN7_MULDIV && !M_EXT) begin
                        ctrl.illegal = 1'b1;
                    end else begin
                        ctrl.mux_result      = RES_ALU;
                        ctrl.mux_wire_module = WM_R;
                        ctrl.mux_d_mem       = 1'b1;
                        ctrl.wrten_reg       = 1'b1;
                        ctrl.muldiv          = (fun_7 == FUN7_MULDIV);
                        ctrl.mux_complmnt    = (fun_7 != FUN7_MULDIV) && fun_7[5];
                        ctrl.alu_op          = {WIDE_ALU_OP && fun_7[5], fun_3};
                    end
                end
                default: ctrl.illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/pipelined_control.sv
// Decode-stage control with ID/EX control register, load-use/cache/mul-div stall and flush bubbles.
module pipelined_control
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_OP_W     = 4,
    parameter int REG_ADDR_W   = 5,
    parameter int ENABLE_M_EXT = 0
) (
    input logic               clk,
    input logic               reset_n,
    pipelined_control_if.slave bus
);
    ctrl_t                 dec;
    ctrl_t                 ex_q;
    logic                  ex_valid_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    state_t                state;
    logic                  flush_pend;
    logic                  mem_cond;
    logic                  mul_cond;
    logic                  hold;
    logic                  load_use;
    logic                  kill;

    ctrl_decode #(
        .ALU_OP_W     (ALU_OP_W),
        .ENABLE_M_EXT (ENABLE_M_EXT)
    ) u_decode (
        .instr_valid (bus.instr_valid),
        .opcode      (bus.opcode),
        .fun_3       (bus.fun_3),
        .fun_7       (bus.fun_7),
        .ctrl        (dec)
    );

    assign mem_cond = ex_valid_q & (ex_q.d_mem_r | ex_q.d_mem_w) & bus.d_mem_busy;
    assign mul_cond = ex_valid_q & ex_q.muldiv & ~bus.muldiv_done;

    // Waits are judged on the live condition so stall_id drops in the cycle it clears.
    always_comb begin
        hold = 1'b0;
        case (state)
            RUN:      hold = mem_cond | mul_cond;
            MEM_WAIT: hold = mem_cond;
            MUL_WAIT: hold = mul_cond;
            default:  hold = 1'b0;
        endcase
    end

    assign load_use = ex_valid_q & ex_q.d_mem_r & (ex_rd_q != '0) & bus.instr_valid
                    & ((ex_rd_q == bus.rs1) | (ex_rd_q == bus.rs2));
    assign kill     = bus.flush | flush_pend;

    assign bus.stall_id = hold | (load_use & ~kill);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            flush_pend <= 1'b0;
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
        end else begin
            // NOTE: non-blocking so every branch below sees this cycle's state, not a partial update.
            state <= mem_cond ? MEM_WAIT : (mul_cond ? MUL_WAIT : RUN);
            if (hold) begin
                if (bus.flush) flush_pend <= 1'b1;
            end else begin
                flush_pend <= 1'b0;
                if (kill || load_use) begin
                    ex_q       <= '0;
                    ex_valid_q <= 1'b0;
                    ex_rd_q    <= '0;
                end else begin
                    ex_q       <= dec;
                    ex_valid_q <= bus.instr_valid;
                    ex_rd_q    <= bus.instr_valid ? bus.rd : '0;
                end
            end
        end
    end

    assign bus.ex_valid           = ex_valid_q;
    assign bus.ex_rd              = ex_rd_q;
    assign bus.ex_d_mem_r         = ex_q.d_mem_r;
    assign bus.ex_d_mem_w         = ex_q.d_mem_w;
    assign bus.ex_jump            = ex_q.jump;
    assign bus.ex_branch          = ex_q.branch;
    assign bus.ex_wrten_reg       = ex_q.wrten_reg;
    assign bus.ex_mux_d_mem       = ex_q.mux_d_mem;
    assign bus.ex_mux_inp_1       = ex_q.mux_inp_1;
    assign bus.ex_mux_inp_2       = ex_q.mux_inp_2;
    assign bus.ex_mux_complmnt    = ex_q.mux_complmnt;
    assign bus.ex_muldiv          = ex_q.muldiv;
    assign bus.ex_illegal         = ex_q.illegal;
    assign bus.ex_mux_result      = ex_q.mux_result;
    assign bus.ex_mux_wire_module = ex_q.mux_wire_module;
    assign bus.ex_alu_op          = ex_q.alu_op[ALU_OP_W-1:0];
endmodule

// File: tb/tb_pipelined_control.sv
// Directed scoreboard bench for pipelined_control; a second instance checks the M-disabled decode.
module tb_pipelined_control;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    pipelined_control_if #(.ALU_OP_W(4), .REG_ADDR_W(5)) bus ();
    pipelined_control_if #(.ALU_OP_W(4), .REG_ADDR_W(5)) bus_nm ();

    pipelined_control #(.ALU_OP_W(4), .REG_ADDR_W(5), .ENABLE_M_EXT(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    pipelined_control #(.ALU_OP_W(4), .REG_ADDR_W(5), .ENABLE_M_EXT(0)) dut_nm (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_nm.slave)
    );

    assign bus_nm.instr_valid = bus.instr_valid;
    assign bus_nm.opcode      = bus.opcode;
    assign bus_nm.fun_3       = bus.fun_3;
    assign bus_nm.fun_7       = bus.fun_7;
    assign bus_nm.rs1         = bus.rs1;
    assign bus_nm.rs2         = bus.rs2;
    assign bus_nm.rd          = bus.rd;
    assign bus_nm.flush       = bus.flush;
    assign bus_nm.d_mem_busy  = bus.d_mem_busy;
    assign bus_nm.muldiv_done = bus.muldiv_done;

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rd;
        ctrl_t      c;
    } exp_t;

    exp_t sb[$];

    function automatic ctrl_t enc(logic [1:0] res, logic [2:0] wm, logic i1, logic i2,
                                  logic dm, logic wr);
        ctrl_t c = '0;
        c.mux_result      = res;
        c.mux_wire_module = wm;
        c.mux_inp_1       = i1;
        c.mux_inp_2       = i2;
        c.mux_d_mem       = dm;
        c.wrten_reg       = wr;
        return c;
    endfunction

    // Reference decode taken straight from the encoding table.
    function automatic ctrl_t model(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, bit mext);
        ctrl_t c = '0;
        case (op)
            7'b0110111: c = enc(2'd1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
            7'b0010111: c = enc(2'd2, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
            7'b1101111: begin c = enc(2'd3, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1); c.jump = 1'b1; end
            7'b1100111: begin c = enc(2'd3, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1); c.jump = 1'b1; end
            7'b1100011: begin c.branch = 1'b1; c.mux_complmnt = 1'b1; end
            7'b0000011: begin c = enc(2'd2, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1); c.d_mem_r = 1'b1; end
            7'b0100011: begin c = enc(2'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0); c.d_mem_w = 1'b1; end
            7'b0010011: begin
                c = enc(2'd2, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1);
                c.alu_op = {(f3 == 3'b101) & f7[5], f3};
            end
            7'b0110011: begin
                if (f7 == 7'b0000001) begin
                    if (mext) begin
                        c = enc(2'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
                        c.muldiv = 1'b1;
                        c.alu_op = {1'b0, f3};
                    end else begin
                        c.illegal = 1'b1;
                    end
                end else begin
                    c = enc(2'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
                    c.mux_complmnt = f7[5];
                    c.alu_op = {f7[5], f3};
                end
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic ctrl_t observed();
        ctrl_t c;
        c.d_mem_r         = bus.ex_d_mem_r;
        c.d_mem_w         = bus.ex_d_mem_w;
        c.jump            = bus.ex_jump;
        c.branch          = bus.ex_branch;
        c.wrten_reg       = bus.ex_wrten_reg;
        c.mux_d_mem       = bus.ex_mux_d_mem;
        c.mux_inp_1       = bus.ex_mux_inp_1;
        c.mux_inp_2       = bus.ex_mux_inp_2;
        c.mux_complmnt    = bus.ex_mux_complmnt;
        c.muldiv          = bus.ex_muldiv;
        c.illegal         = bus.ex_illegal;
        c.mux_result      = bus.ex_mux_result;
        c.mux_wire_module = bus.ex_mux_wire_module;
        c.alu_op          = bus.ex_alu_op;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.fun_3       = f3;
        bus.fun_7       = f7;
        bus.rs1         = rs1;
        bus.rs2         = rs2;
        bus.rd          = rd;
    endtask

    task automatic idle();
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.fun_3       = '0;
        bus.fun_7       = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;
        bus.rd          = '0;
    endtask

    task automatic push_instr(input logic [4:0] rd);
        exp_t e;
        e.valid = 1'b1;
        e.rd    = rd;
        e.c     = model(bus.opcode, bus.fun_3, bus.fun_7, 1'b1);
        sb.push_back(e);
    endtask

    task automatic push_bubble();
        exp_t e;
        e.valid = 1'b0;
        e.rd    = '0;
        e.c     = '0;
        sb.push_back(e);
    endtask

    task automatic push_held(input exp_t e);
        sb.push_back(e);
    endtask

    // Check the stall for the current inputs, clock once, then compare EX against the scoreboard.
    task automatic step(input string tag, input logic exp_stall);
        exp_t e;
        #1;
        check({tag, "_stall"}, 32'(bus.stall_id), 32'(exp_stall));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(bus.ex_valid), 32'(e.valid));
            check({tag, "_rd"}, 32'(bus.ex_rd), 32'(e.rd));
            check({tag, "_ctrl"}, 32'(observed()), 32'(e.c));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t lw_e;
        exp_t mul_e;
        logic [16:0] table_v [8];

        reset_n         = 1'b0;
        bus.flush       = 1'b0;
        bus.d_mem_busy  = 1'b0;
        bus.muldiv_done = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ex_valid", 32'(bus.ex_valid), 32'(0));
        check("reset_stall", 32'(bus.stall_id), 32'(0));
        check("reset_ctrl", 32'(observed()), 32'(0));
        reset_n = 1'b1;

        // ADDI x1 then SUB x2
        drive(7'b0010011, 3'b000, 7'b0000000, 5'd0, 5'd5, 5'd1);
        push_instr(5'd1);
        step("addi", 1'b0);
        check("addi_alu_op", 32'(bus.ex_alu_op), 32'(4'b0000));
        check("addi_wm", 32'(bus.ex_mux_wire_module), 32'(3'd4));
        drive(7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd4, 5'd2);
        push_instr(5'd2);
        step("sub", 1'b0);
        check("sub_alu_op", 32'(bus.ex_alu_op), 32'(4'b1000));
        check("sub_complmnt", 32'(bus.ex_mux_complmnt), 32'(1));

        // Load-use: LW x5 then ADD x6,x5,x7
        drive(7'b0000011, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd5);
        push_instr(5'd5);
        step("lw5", 1'b0);
        drive(7'b0110011, 3'b000, 7'b0000000, 5'd5, 5'd7, 5'd6);
        push_bubble();
        step("lu_bubble", 1'b1);
        push_instr(5'd6);
        step("lu_add", 1'b0);

        // LW x0 then a use of x0: no stall
        drive(7'b0000011, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd0);
        push_instr(5'd0);
        step("lw0", 1'b0);
        drive(7'b0110011, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd6);
        push_instr(5'd6);
        step("x0_use", 1'b0);

        // Cache busy for 3 cycles with a flush pulse inside the wait
        drive(7'b0000011, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd5);
        push_instr(5'd5);
        lw_e = sb[0];
        step("mw_lw", 1'b0);
        drive(7'b0010011, 3'b000, 7'b0000000, 5'd1, 5'd0, 5'd9);
        bus.d_mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.flush = (i == 1);
            push_held(lw_e);
            step("mw_hold", 1'b1);
        end
        bus.flush      = 1'b0;
        bus.d_mem_busy = 1'b0;
        push_bubble();
        step("mw_flush_bubble", 1'b0);
        push_instr(5'd9);
        step("mw_after", 1'b0);

        // MUL: wait for muldiv_done; M-disabled instance decodes it as illegal
        drive(7'b0110011, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd10);
        push_instr(5'd10);
        mul_e = sb[0];
        step("mul", 1'b0);
        check("nm_illegal", 32'(bus_nm.ex_illegal), 32'(1));
        check("nm_wrten", 32'(bus_nm.ex_wrten_reg), 32'(0));
        drive(7'b0010011, 3'b000, 7'b0000000, 5'd1, 5'd0, 5'd11);
        for (int i = 0; i < 2; i++) begin
            push_held(mul_e);
            step("mul_hold", 1'b1);
        end
        bus.muldiv_done = 1'b1;
        push_instr(5'd11);
        step("mul_done", 1'b0);
        bus.muldiv_done = 1'b0;

        // Flush and load-use together: flush wins, no stall
        drive(7'b0000011, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd5);
        push_instr(5'd5);
        step("fp_lw", 1'b0);
        drive(7'b0110011, 3'b000, 7'b0000000, 5'd5, 5'd0, 5'd6);
        bus.flush = 1'b1;
        push_bubble();
        step("fp_flush", 1'b0);
        bus.flush = 1'b0;

        // Unknown opcode
        drive(7'b1111111, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd4);
        push_instr(5'd4);
        step("unknown", 1'b0);
        check("unknown_illegal", 32'(bus.ex_illegal), 32'(1));
        check("unknown_wrten", 32'(bus.ex_wrten_reg), 32'(0));

        // Remaining formats, including SRAI/SRLI qualifier and OR-immediate
        table_v[0] = {7'b0110111, 3'b000, 7'b0000000};
        table_v[1] = {7'b0010111, 3'b000, 7'b0000000};
        table_v[2] = {7'b1101111, 3'b000, 7'b0100000};
        table_v[3] = {7'b1100111, 3'b000, 7'b0000000};
        table_v[4] = {7'b1100011, 3'b001, 7'b0000000};
        table_v[5] = {7'b0100011, 3'b010, 7'b0100000};
        table_v[6] = {7'b0010011, 3'b101, 7'b0100000};
        table_v[7] = {7'b0010011, 3'b110, 7'b0100000};
        for (int i = 0; i < 8; i++) begin
            drive(table_v[i][16:10], table_v[i][9:7], table_v[i][6:0], 5'd0, 5'd0, 5'd3);
            push_instr(5'd3);
            step("fmt", 1'b0);
        end

        // instr_valid low gives a zero bundle
        idle();
        push_bubble();
        step("idle", 1'b0);

        // Asynchronous reset in the middle of a cache wait
        drive(7'b0000011, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd5);
        push_instr(5'd5);
        step("rst_lw", 1'b0);
        idle();
        bus.d_mem_busy = 1'b1;
        #1;
        check("rst_pre_stall", 32'(bus.stall_id), 32'(1));
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(bus.ex_valid), 32'(0));
        check("rst_async_stall", 32'(bus.stall_id), 32'(0));
        check("rst_async_ctrl", 32'(observed()), 32'(0));
        check("rst_async_rd", 32'(bus.ex_rd), 32'(0));
        bus.d_mem_busy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
